// File: rtl/engine_forward_data_sequencer_pkg.sv
// Shared definitions for the forward-data engine sequencer.
//   NUM_BUNDLES_WIDTH_BITS : width of the ForwardDataConfiguration hops field
//   engine_forward_data_sequencer_state : control FSM state encoding
package engine_forward_data_sequencer_pkg;

  localparam int unsigned NUM_BUNDLES_WIDTH_BITS = 8;

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_CONFIG_REQ,
    S_CONFIG_WAIT,
    S_BUSY,
    S_DRAIN,
    S_DONE
  } engine_forward_data_sequencer_state;

endpackage

// File: rtl/engine_forward_data_sequencer_counter.sv
// Clear / increment counter that wraps modulo 2^W.
// Used for the forwarded-packet count and for the config-wait watchdog.
//   ap_clk : clock
//   areset : synchronous active-high reset (count -> 0)
//   clr    : synchronous clear, dominates inc
//   inc    : add one
//   count  : current value
module engine_forward_data_sequencer_counter #(
  parameter int unsigned W = 32
) (
  input  logic         ap_clk,
  input  logic         areset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge ap_clk) begin
    if (areset || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/engine_forward_data_sequencer.sv
// Control FSM for one forward-data engine. Waits for the configure FIFO to
// leave reset, pops one configuration entry, latches its hops field, then
// forwards a valid/backpressure packet stream stamped with those hops and
// counts packets until the lane signals done.
//
// Optional build macro: ENGINE_FORWARD_DATA_SEQUENCER_TIMEOUT_EN adds a
// config-wait watchdog (TIMEOUT_CYCLES) that raises error_out.
//
// Ports:
//   ap_clk, areset                  : clock, synchronous active-high reset
//   start_in, done_in               : run start pulse, lane completion
//   fifo_setup_signal_in            : configure FIFO still in reset
//   config_valid_in/config_hops_in  : configure FIFO output
//   config_rd_en_out                : configure FIFO pop
//   data_in_valid/data_in           : upstream packet
//   data_in_ready                   : upstream pop
//   data_out_full                   : downstream prog_full
//   data_out_valid/data_out/_hops   : downstream push, payload, hops
//   pkt_count_out                   : packets forwarded this run
//   busy_out, done_out, error_out   : run status
module engine_forward_data_sequencer
  import engine_forward_data_sequencer_pkg::*;
#(
  parameter int unsigned HOPS_W         = NUM_BUNDLES_WIDTH_BITS,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              ap_clk,
  input  logic              areset,
  input  logic              start_in,
  input  logic              done_in,
  input  logic              fifo_setup_signal_in,
  input  logic              config_valid_in,
  input  logic [HOPS_W-1:0] config_hops_in,
  output logic              config_rd_en_out,
  input  logic              data_in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              data_in_ready,
  input  logic              data_out_full,
  output logic              data_out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [HOPS_W-1:0] data_out_hops,
  output logic [CNT_W-1:0]  pkt_count_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              error_out
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  engine_forward_data_sequencer_state state, state_next;

  // Registered copies of every input; all decisions use these.
  logic              start_r, done_r, setup_r, cfg_valid_r;
  logic [HOPS_W-1:0] cfg_hops_r;
  logic              din_valid_r, full_r;
  logic [DATA_W-1:0] din_r;

  logic              start_go;
  logic              accept;
  logic              timeout_hit;
  logic              timeout_fire;
  logic [HOPS_W-1:0] hops_q;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      start_r     <= 1'b0;
      done_r      <= 1'b0;
      setup_r     <= 1'b0;
      cfg_valid_r <= 1'b0;
      cfg_hops_r  <= '0;
      din_valid_r <= 1'b0;
      din_r       <= '0;
      full_r      <= 1'b0;
    end else begin
      start_r     <= start_in;
      done_r      <= done_in;
      setup_r     <= fifo_setup_signal_in;
      cfg_valid_r <= config_valid_in;
      cfg_hops_r  <= config_hops_in;
      din_valid_r <= data_in_valid;
      din_r       <= data_in;
      full_r      <= data_out_full;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state <= S_RESET;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    config_rd_en_out = 1'b0;
    busy_out         = 1'b0;
    done_out         = 1'b0;
    start_go         = 1'b0;
    accept           = 1'b0;
    timeout_fire     = 1'b0;
    case (state)
      S_RESET: state_next = S_IDLE;
      S_IDLE: begin
        if (!setup_r && start_r) begin
          start_go   = 1'b1;
          state_next = S_CONFIG_REQ;
        end
      end
      S_CONFIG_REQ: begin
        busy_out         = 1'b1;
        config_rd_en_out = 1'b1;
        state_next       = S_CONFIG_WAIT;
      end
      S_CONFIG_WAIT: begin
        busy_out = 1'b1;
        if (cfg_valid_r) begin
          state_next = S_BUSY;
        end else if (timeout_hit) begin
          timeout_fire = 1'b1;
          state_next   = S_DONE;
        end
      end
      S_BUSY: begin
        busy_out = 1'b1;
        accept   = din_valid_r && !full_r;
        if (done_r) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy_out   = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done_out = 1'b1;
        if (start_r) begin
          start_go   = 1'b1;
          state_next = S_CONFIG_REQ;
        end
      end
      default: state_next = S_RESET;
    endcase
  end

  assign data_in_ready = accept;
  assign data_out_hops = hops_q;

  // Leaving S_CONFIG_WAIT on the first valid makes later pulses harmless.
  // With hops == 0 packets are still consumed and counted, just not pushed.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      hops_q         <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      if (state == S_CONFIG_WAIT && cfg_valid_r) begin
        hops_q <= cfg_hops_r;
      end
      if (accept) begin
        data_out <= din_r;
      end
      data_out_valid <= accept && (hops_q != '0);
    end
  end

  engine_forward_data_sequencer_counter #(.W(CNT_W)) u_pkt_count (
    .ap_clk (ap_clk),
    .areset (areset),
    .clr    (start_go),
    .inc    (accept),
    .count  (pkt_count_out)
  );

`ifdef ENGINE_FORWARD_DATA_SEQUENCER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WD_W-1:0] wd_count;
  logic            wd_clr;
  logic            wd_inc;
  logic            error_q;

  assign wd_clr = (state != S_CONFIG_WAIT);
  assign wd_inc = (state == S_CONFIG_WAIT);

  engine_forward_data_sequencer_counter #(.W(WD_W)) u_watchdog (
    .ap_clk (ap_clk),
    .areset (areset),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .count  (wd_count)
  );

  // Count holds k-1 during the k-th wait cycle, so this fires on wait cycle
  // TIMEOUT_CYCLES.
  assign timeout_hit = (state == S_CONFIG_WAIT) &&
                       (wd_count == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      error_q <= 1'b0;
    end else if (start_go) begin
      error_q <= 1'b0;
    end else if (timeout_fire) begin
      error_q <= 1'b1;
    end
  end

  assign error_out = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error_out   = 1'b0;
`endif

endmodule

// File: doc/engine_forward_data_sequencer.md
Name: engine_forward_data_sequencer

Overview:
- Control FSM for one forward-data engine.
- Holds the forward datapath idle until the configure-memory FIFO leaves reset, then pops exactly one ForwardDataConfiguration entry and latches its hops field.
- Then gates a valid/backpressure packet stream, stamping each packet with the latched hops, and counts packets until the owning lane signals completion.
- Sits between the engine's configure-memory block and its forwarding output FIFO.

Parameters:
- HOPS_W, NUM_BUNDLES_WIDTH_BITS: width of the hops field.
- DATA_W, 32: forwarded payload width.
- CNT_W, 32: width of the forwarded-packet counter.
- TIMEOUT_CYCLES, 1024: config-wait watchdog limit; used only with the optional feature.

Ports:
- ap_clk, input, 1: clock.
- areset, input, 1: synchronous active-high reset.
- start_in, input, 1: one-cycle pulse that begins a configuration/run.
- done_in, input, 1: lane says no more input packets will arrive.
- fifo_setup_signal_in, input, 1: configure FIFO still resetting.
- config_valid_in, input, 1: configure FIFO dout valid.
- config_hops_in, input, HOPS_W: hops field of the configuration payload.
- config_rd_en_out, output, 1: configure FIFO pop request.
- data_in_valid, input, 1: upstream packet valid.
- data_in, input, DATA_W: upstream payload.
- data_in_ready, output, 1: upstream pop.
- data_out_full, input, 1: downstream prog_full.
- data_out_valid, output, 1: downstream push.
- data_out, output, DATA_W: registered payload.
- data_out_hops, output, HOPS_W: latched hops.
- pkt_count_out, output, CNT_W: packets forwarded this run.
- busy_out, output, 1: FSM is between start acceptance and DONE.
- done_out, output, 1: run complete; held until the next start.
- error_out, output, 1: watchdog fired; only with the optional feature.

Behaviour:
- Reset clears all outputs to 0, the FSM to S_RESET, and the counter and latched hops to 0. Inputs are registered once internally, so every decision is made on 1-cycle-delayed input values.
- S_RESET → S_IDLE unconditionally on the next cycle.
- S_IDLE:
  - Stay while fifo_setup_signal_in=1.
  - Otherwise, start_in=1 → S_CONFIG_REQ. Clear pkt_count_out and done_out; busy_out=1.
  - start_in while fifo_setup_signal_in=1 is dropped, not queued.
- S_CONFIG_REQ: config_rd_en_out=1 for exactly one cycle → S_CONFIG_WAIT.
- S_CONFIG_WAIT:
  - On config_valid_in, latch config_hops_in into data_out_hops → S_BUSY.
  - Further config_valid_in pulses are ignored; only the first is latched.
- S_BUSY:
  - data_in_ready = data_in_valid & ~data_out_full. This is combinational from the registered inputs.
  - Each accepted packet appears on data_out/data_out_valid one cycle later, and pkt_count_out increments in that same cycle.
  - If latched hops==0, packets are consumed (ready=1, counter increments) but data_out_valid stays 0.
  - done_in=1 → S_DRAIN. done_in has priority over nothing: a packet accepted in the same cycle is still forwarded and counted.
- S_DRAIN: wait one cycle for the output register to empty → S_DONE.
- S_DONE:
  - done_out=1, busy_out=0.
  - start_in → S_CONFIG_REQ. Counter clears and data_out_hops keeps its value until the new config is latched.
- Counter wraps modulo 2^CNT_W with no saturation.
- data_out_full held high in S_BUSY: no loss, no duplication; data_in_ready=0.
- start_in outside S_IDLE and S_DONE is ignored.
- areset mid-run returns to S_RESET on the next edge. Any in-flight output is discarded and data_out_valid=0 the cycle after reset is sampled.

Optional Feature:
- ENGINE_FORWARD_DATA_SEQUENCER_TIMEOUT_EN defined:
  - A wait counter runs in S_CONFIG_WAIT.
  - When it reaches TIMEOUT_CYCLES without config_valid_in, set error_out=1 (sticky until reset or the next start_in) and go to S_DONE with done_out=1.
- Undefined:
  - No wait counter is built; S_CONFIG_WAIT waits forever.
  - error_out is tied to 0.

Decomposition:
- Shared package:
  - State enum type engine_forward_data_sequencer_state.
  - Reuse of the existing ForwardDataConfiguration/hops width constant NUM_BUNDLES_WIDTH_BITS.
- Sub-module: engine_forward_data_sequencer_counter. Clear/increment/wrap counter, reused for both the packet count and the watchdog.

Test Plan:
- Reset/setup gating: hold fifo_setup_signal_in=1 for 10 cycles while pulsing start_in → no config_rd_en_out. Then deassert and pulse start → config_rd_en_out high exactly 1 cycle.
- Basic run: config_hops_in=3 valid, then 8 back-to-back packets 0x10..0x17, then done_in → data_out sequence 0x10..0x17, data_out_hops=3, pkt_count_out=8, done_out=1.
- Backpressure: data_out_full toggled every other cycle during 20 packets → 20 outputs, in order, none duplicated; pkt_count_out=20.
- hops=0: 5 packets → data_out_valid never asserts; pkt_count_out=5; done_out=1 after done_in.
- Reset mid-run: areset after 3 of 6 packets → all outputs 0 next cycle. A fresh run with hops=2 and 4 packets then gives pkt_count_out=4.
- Watchdog (macro on, TIMEOUT_CYCLES=16): start with no config_valid_in → error_out=1 and done_out=1 at wait cycle 16. Macro off → FSM still in S_CONFIG_WAIT after 100 cycles.
